// File: rtl/display_if.sv
// Bus-side signal bundle for the seven-segment display driver.
// The CPU side uses master; the driver itself uses slave.
interface display_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DIGITS = 4
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] bus;
    logic                  signed_mode;
    logic                  blank;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic                  busy;
    logic                  overflow;
    logic [7:0]            segments;
    logic [NUM_DIGITS-1:0] digit;

    modport master (
        output enable, bus, signed_mode, blank, dp_mask,
        input  busy, overflow, segments, digit
    );

    modport slave (
        input  enable, bus, signed_mode, blank, dp_mask,
        output busy, overflow, segments, digit
    );
endinterface

// File: rtl/display_driver.sv
// Multiplexed seven-segment driver: sequential binary-to-BCD conversion,
// atomic commit to a display buffer, and continuous digit scanning.
module display_driver #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1,
    parameter int COMMON_ANODE = 0
) (
    input logic      sys_clk,
    input logic      rst,
    display_if.slave disp
);
    function automatic int bcd_digits_for(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 0;
        do begin
            n++;
            v = v / 10;
        end while (v > 0);
        return n;
    endfunction

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 8'h3F;
            4'd1:    seg_encode = 8'h06;
            4'd2:    seg_encode = 8'h5B;
            4'd3:    seg_encode = 8'h4F;
            4'd4:    seg_encode = 8'h66;
            4'd5:    seg_encode = 8'h6D;
            4'd6:    seg_encode = 8'h7D;
            4'd7:    seg_encode = 8'h07;
            4'd8:    seg_encode = 8'h7F;
            4'd9:    seg_encode = 8'h6F;
            default: seg_encode = 8'h00;
        endcase
    endfunction

    localparam int BCD_DIGITS = bcd_digits_for(DATA_WIDTH);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int PAD_DIGITS = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;
    localparam int PAD_W      = 4 * PAD_DIGITS;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int ITER_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT_INV = {NUM_DIGITS{COMMON_ANODE != 0}};
    localparam logic [7:0]            SEG_INV   = {8{COMMON_ANODE != 0}};

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] mag_reg, capture_mag;
    logic [BCD_W-1:0]      bcd_reg, bcd_adj, bcd_shift;
    logic [PAD_W-1:0]      bcd_pad;
    logic [ITER_W-1:0]     iter_reg;
    logic                  neg_reg, blank_reg, capture_neg;
    logic                  overflow_reg, commit_ovf;
    logic [7:0]            buffer_reg [NUM_DIGITS];
    logic [7:0]            commit_buf [NUM_DIGITS];
    int                    sig_digits, minus_pos;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [NUM_DIGITS-1:0] digit_reg, digit_next;
    logic [7:0]            seg_reg, seg_next;

    // A new load strobe always wins, even mid-conversion or in COMMIT.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (disp.enable) begin
            state_next = CONVERT;
        end else begin
            case (state_reg)
                CONVERT: if (iter_reg == ITER_W'(DATA_WIDTH - 1)) state_next = COMMIT;
                COMMIT:  state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    assign capture_neg = disp.signed_mode & disp.bus[DATA_WIDTH-1];
    assign capture_mag = capture_neg ? (~disp.bus) + DATA_WIDTH'(1) : disp.bus;

    // Double-dabble: correct every nibble >= 5, then shift in the next magnitude bit.
    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate
    assign bcd_shift = BCD_W'({bcd_adj, mag_reg[DATA_WIDTH-1]});
    assign bcd_pad   = PAD_W'(bcd_reg);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            mag_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
            neg_reg   <= 1'b0;
            blank_reg <= 1'b0;
        end else if (disp.enable) begin
            mag_reg   <= capture_mag;
            bcd_reg   <= '0;
            iter_reg  <= '0;
            neg_reg   <= capture_neg;
            blank_reg <= disp.blank;
        end else if (state_reg == CONVERT) begin
            mag_reg  <= mag_reg << 1;
            bcd_reg  <= bcd_shift;
            iter_reg <= iter_reg + ITER_W'(1);
        end
    end

    always_comb begin
        sig_digits = 1;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd_pad[4*i +: 4] != 4'd0) sig_digits = i + 1;
        commit_ovf = (sig_digits > NUM_DIGITS) || (neg_reg && (sig_digits + 1 > NUM_DIGITS));
        minus_pos  = blank_reg ? sig_digits : NUM_DIGITS - 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit_ovf)                      commit_buf[i] = 8'h40;
            else if (neg_reg && i == minus_pos)  commit_buf[i] = 8'h40;
            else if (i < sig_digits)             commit_buf[i] = seg_encode(bcd_pad[4*i +: 4]);
            else                                 commit_buf[i] = blank_reg ? 8'h00 : 8'h3F;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) buffer_reg[i] <= 8'h3F;
        end else if (state_reg == COMMIT && !disp.enable) begin
            overflow_reg <= commit_ovf;
            for (int i = 0; i < NUM_DIGITS; i++) buffer_reg[i] <= commit_buf[i];
        end
    end

    // Digit select and segments are both derived from idx_next so they stay aligned.
    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
        if (cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
        end
        seg_next = buffer_reg[idx_next] | (disp.dp_mask[idx_next] ? 8'h80 : 8'h00);
    end

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
            assign digit_next[gi] = (idx_next == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            digit_reg <= DIGIT_INV ^ NUM_DIGITS'(1);
            seg_reg   <= SEG_INV ^ 8'h3F;
        end else begin
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            digit_reg <= DIGIT_INV ^ digit_next;
            seg_reg   <= SEG_INV ^ seg_next;
        end
    end

    assign disp.busy     = (state_reg != IDLE);
    assign disp.overflow = overflow_reg;
    assign disp.segments = seg_reg;
    assign disp.digit    = digit_reg;
endmodule

// File: doc/display_driver.md
Name: display_driver

Overview:
- Parametrised multiplexed seven-segment display driver for the CPU output register.
- Captures a binary value from the bus on a load strobe and converts it to BCD sequentially (shift-add-3, one bit per clock).
- Commits the result atomically to a display buffer, then time-multiplexes NUM_DIGITS digits with a programmable refresh rate.
- Adds signed display, leading-zero blanking, decimal points and overflow indication.

Parameters:
- DATA_WIDTH, 8, width of the bus value (2..16).
- NUM_DIGITS, 4, number of physical digits (2..8).
- REFRESH_DIV, 1, sys_clk cycles each digit stays active (>=1).
- COMMON_ANODE, 0, 0 = active-high segments and digits; 1 = both inverted.

Ports:
- sys_clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  load strobe; bus, signed_mode and blank are sampled when high.
- bus  input  DATA_WIDTH  value to display.
- signed_mode  input  1  1 = bus is two's complement.
- blank  input  1  1 = suppress leading zeros.
- dp_mask  input  NUM_DIGITS  bit i lights the DOT of digit i; live, not latched.
- busy  output  1  conversion in progress.
- overflow  output  1  committed value did not fit.
- segments  output  8  bit0..bit6 = A..G, bit7 = DOT; registered.
- digit  output  NUM_DIGITS  one-hot digit select; bit 0 = rightmost digit; registered.

Behaviour:
- Reset (async): FSM=IDLE, busy=0, overflow=0, committed value = 0 (unsigned, no blanking), refresh counter=0, scan index=0, digit=...0001, segments=8'h3F. With COMMON_ANODE=1, digit and segments reset to the bitwise inverse.
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: enable=1 captures the operands -> CONVERT.
  - CONVERT: runs exactly DATA_WIDTH iterations -> COMMIT.
  - COMMIT: one cycle; writes the display buffer -> IDLE.
- Capture: takes bus, signed_mode and blank. If signed_mode=1 and bus MSB=1, magnitude = two's-complement negation as unsigned DATA_WIDTH bits (-128 -> 128) and neg=1. Otherwise magnitude = bus and neg=0.
- Latency: enable sampled at edge T. busy=1 after T. Iterations run on edges T+1..T+DATA_WIDTH. Commit and busy=0 occur at edge T+DATA_WIDTH+1.
- enable=1 in CONVERT or COMMIT: aborts the current conversion and recaptures (same as IDLE capture). The display buffer is unchanged until a conversion completes.
- Internal BCD register holds enough digits for 2^DATA_WIDTH-1. The BCD register is cleared at capture. Each iteration adds 3 to every nibble >=5, then shifts in the magnitude MSB first.
- Commit rules:
  - Let m = number of significant decimal digits (m=1 for value 0).
  - overflow=1 if m > NUM_DIGITS, or if neg and m+1 > NUM_DIGITS. Otherwise overflow=0.
  - Overflow: all digits show G only (dash).
  - Normal: digits 0..m-1 show decimal values. Digits >=m show 0 if blank=0, blank (8'h00) if blank=1.
  - neg: minus (G only) goes in digit m if blank=1, otherwise in digit NUM_DIGITS-1.
- Encodings: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Minus = 40. Blank = 00.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps and the scan index advances (N-1 wraps to 0).
  - digit and segments are registered from the same next index in the same cycle, so they are never misaligned.
  - segments = buffer[index] | (dp_mask[index] ? 8'h80 : 0).
  - Scanning runs continuously, including during conversion.
- COMMON_ANODE=1: invert digit and segments at the output registers only.

Test Plan:
- Reset, then bus=8'd0 with enable for 1 cycle -> busy high for exactly 9 cycles; buffer = 3F,3F,3F,3F with blank=0; overflow=0.
- bus=8'd157, blank=1, REFRESH_DIV=1 -> scan sequence digit 0001/07, 0010/6D, 0100/06, 1000/00, repeating every 4 cycles.
- bus=8'h80, signed_mode=1, blank=1 -> digits 0..3 = 7F,5B,06,40 ("-128"); same with blank=0 -> identical, since the minus lands in digit 3 either way.
- NUM_DIGITS=2, bus=8'd100 -> overflow=1, both digits 40. Then bus=8'hFF signed -> "-1" shown as 40,06, overflow=0.
- Load 8'd42; at cycle T+3 assert enable with bus=8'd7 -> 42 never committed; 7 committed at T+3+9; display holds the previous value until then.
- REFRESH_DIV=3, dp_mask=4'b0010 -> each digit active 3 cycles; segment bit7 set only while digit=0010. Assert rst mid-scan and mid-conversion -> immediate return to reset values, busy=0.
